// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl
// Bit-serial ALU sequencer: takes one full-width operation through a
// start/done handshake and walks a single 1-bit ALU slice across the
// operands LSB first, with a carry flop linking consecutive bits and an
// extra fix-up cycle that turns the MSB sum into a set-less-than result.

module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);

  // Bit counter only ever needs to reach WIDTH-1; it is compared, not wrapped.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // Sequencer states.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] SLT  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [1:0]       nextState;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] aSh;
  logic [WIDTH-1:0] bSh;
  logic [2:0]       opReg;
  logic             carry;
  logic [WIDTH-1:0] resultSh;
  logic             msbSum;
  logic             zeroReg;
  logic             carryOutReg;
  logic             overflowReg;

  logic             ai;
  logic             bi;
  logic             sumBit;
  logic             carryNext;
  logic             outBit;
  logic             lastBit;
  logic [WIDTH-1:0] shiftedResult;

  // One-bit ALU slice fed from the bottom of the operand shift registers;
  // op bit 2 inverts b so that SUB and SLT form a + ~b + 1.
  always_comb begin
    ai            = aSh[0];
    bi            = bSh[0] ^ opReg[2];
    sumBit        = ai ^ bi ^ carry;
    carryNext     = (ai & bi) | (carry & (ai ^ bi));
    outBit        = 1'b0;
    case (opReg[1:0])
      2'b00:   outBit = ai & bi;
      2'b01:   outBit = sumBit;
      2'b10:   outBit = ai | bi;
      default: outBit = 1'b0;
    endcase
    shiftedResult = {outBit, resultSh[WIDTH-1:1]};
    lastBit       = (state == RUN) && (count == LAST_BIT);
  end

  // Next-state selection: SLT ops take one extra cycle to place the sign bit.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (start) nextState = RUN;
      RUN: begin
        if (lastBit) begin
          nextState = (opReg[1:0] == 2'b11) ? SLT : DONE;
        end
      end
      SLT:     nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Operand/result shift registers, carry flop and bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      aSh      <= '0;
      bSh      <= '0;
      opReg    <= '0;
      carry    <= 1'b0;
      resultSh <= '0;
      msbSum   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            aSh      <= a;
            bSh      <= b;
            opReg    <= alu_op;
            carry    <= alu_op[2];
            count    <= '0;
            resultSh <= '0;
          end
        end
        RUN: begin
          resultSh <= shiftedResult;
          aSh      <= aSh >> 1;
          bSh      <= bSh >> 1;
          carry    <= carryNext;
          if (lastBit) begin
            msbSum <= sumBit;
          end else begin
            count <= count + CW'(1);
          end
        end
        SLT: begin
          resultSh <= {{(WIDTH-1){1'b0}}, msbSum};
        end
        default: begin
        end
      endcase
    end
  end

  // Status flags are loaded on the edge that enters DONE and then held, so
  // they stay stable until the next operation completes. Overflow compares
  // the carry into the MSB with the carry out of it, for ADD/SUB only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zeroReg     <= 1'b0;
      carryOutReg <= 1'b0;
      overflowReg <= 1'b0;
    end else if (lastBit && (opReg[1:0] != 2'b11)) begin
      zeroReg     <= (shiftedResult == '0);
      carryOutReg <= carryNext;
      overflowReg <= (opReg[1:0] == 2'b01) ? (carry ^ carryNext) : 1'b0;
    end else if (state == SLT) begin
      zeroReg     <= ~msbSum;
      carryOutReg <= carry;
      overflowReg <= 1'b0;
    end
  end

  assign busy      = (state == RUN) || (state == SLT);
  assign done      = (state == DONE);
  assign result    = resultSh;
  assign zero      = zeroReg;
  assign carry_out = carryOutReg;
  assign overflow  = overflowReg;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl
// Self-checking bench for the bit-serial ALU sequencer: a table of directed
// operations, a reset-abort sequence and randomized operations checked
// against a word-level arithmetic model.

module tb_alu_serial_ctrl;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [2:0]       aluOp;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carryOut;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
    int          lat;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit          hold;
    exp_t        e;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
    int          lat;
    int          busyLow;
    logic        busyAtDone;
    logic        doneAfter;
    logic        busyAfter;
  } obs_t;

  alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .alu_op    (aluOp),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .zero      (zero),
    .carry_out (carryOut),
    .overflow  (overflow)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Word-level reference: a + (b or ~b) + cin computed as one 33-bit sum.
  function automatic exp_t refModel(input logic [2:0] op, input logic [31:0] av,
                                    input logic [31:0] bv);
    exp_t        e;
    logic [31:0] bEff;
    logic [32:0] s;
    bEff = op[2] ? ~bv : bv;
    s    = {1'b0, av} + {1'b0, bEff} + {32'd0, op[2]};
    case (op[1:0])
      2'b00:   e.res = av & bEff;
      2'b01:   e.res = s[31:0];
      2'b10:   e.res = av | bEff;
      default: e.res = {31'd0, s[31]};
    endcase
    e.c   = s[32];
    e.v   = (op[1:0] == 2'b01) && (av[31] == bEff[31]) && (s[31] != av[31]);
    e.z   = (e.res == 32'd0);
    e.lat = (op[1:0] == 2'b11) ? 34 : 33;
    return e;
  endfunction

  // Single comparison point; counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation from IDLE and follow it to the IDLE cycle after done.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] av,
                               input logic [31:0] bv, input bit hold, output obs_t o);
    int cyc;
    start = 1'b1;
    aluOp = op;
    a     = av;
    b     = bv;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    aluOp = 3'($urandom_range(0, 7));
    cyc       = 1;
    o.busyLow = 0;
    while (!done && cyc < 60) begin
      if (!busy) o.busyLow++;
      @(posedge clk); #1;
      cyc++;
    end
    o.lat        = done ? cyc : -1;
    o.busyAtDone = busy;
    o.res        = result;
    o.z          = zero;
    o.c          = carryOut;
    o.v          = overflow;
    @(posedge clk); #1;
    o.doneAfter = done;
    o.busyAfter = busy;
    start       = 1'b0;
  endtask

  // Run one operation and compare everything observed against expectations.
  task automatic runAndCheck(input string tag, input logic [2:0] op, input logic [31:0] av,
                             input logic [31:0] bv, input bit hold, input exp_t e);
    obs_t o;
    applyStimulus(op, av, bv, hold, o);
    checkOutput({tag, " latency"},      32'(o.lat), 32'(e.lat));
    checkOutput({tag, " result"},       o.res, e.res);
    checkOutput({tag, " zero"},         {31'd0, o.z}, {31'd0, e.z});
    checkOutput({tag, " carry_out"},    {31'd0, o.c}, {31'd0, e.c});
    checkOutput({tag, " overflow"},     {31'd0, o.v}, {31'd0, e.v});
    checkOutput({tag, " busy gaps"},    32'(o.busyLow), 32'd0);
    checkOutput({tag, " busy at done"}, {31'd0, o.busyAtDone}, 32'd0);
    checkOutput({tag, " done after"},   {31'd0, o.doneAfter}, 32'd0);
    checkOutput({tag, " busy after"},   {31'd0, o.busyAfter}, 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    obs_t        o;
    exp_t        e;
    int          doneSeen;
    int          busySeen;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0]  = '{3'b001, 32'd7,        32'd5,        1'b0, '{32'd12,        1'b0, 1'b0, 1'b0, 33}};
    vecs[1]  = '{3'b101, 32'd5,        32'd7,        1'b0, '{32'hFFFFFFFE,  1'b0, 1'b0, 1'b0, 33}};
    vecs[2]  = '{3'b101, 32'h80000000, 32'd1,        1'b0, '{32'h7FFFFFFF,  1'b0, 1'b1, 1'b1, 33}};
    vecs[3]  = '{3'b001, 32'h7FFFFFFF, 32'd1,        1'b0, '{32'h80000000,  1'b0, 1'b0, 1'b1, 33}};
    vecs[4]  = '{3'b001, 32'hFFFFFFFF, 32'd1,        1'b0, '{32'd0,         1'b1, 1'b1, 1'b0, 33}};
    vecs[5]  = '{3'b111, 32'hFFFFFFFF, 32'd1,        1'b0, '{32'd1,         1'b0, 1'b1, 1'b0, 34}};
    vecs[6]  = '{3'b111, 32'd3,        32'd3,        1'b0, '{32'd0,         1'b1, 1'b1, 1'b0, 34}};
    vecs[7]  = '{3'b000, 32'hF0F0A5A5, 32'hFF00FF00, 1'b1, '{32'hF000A500,  1'b0, 1'b1, 1'b0, 33}};
    vecs[8]  = '{3'b010, 32'hF0F0A5A5, 32'hFF00FF00, 1'b1, '{32'hFFF0FFA5,  1'b0, 1'b1, 1'b0, 33}};
    vecs[9]  = '{3'b100, 32'hF0F0A5A5, 32'hFF00FF00, 1'b1, '{32'h00F000A5,  1'b0, 1'b0, 1'b0, 33}};
    vecs[10] = '{3'b110, 32'hF0F0A5A5, 32'hFF00FF00, 1'b1, '{32'hF0FFA5FF,  1'b0, 1'b0, 1'b0, 33}};
    vecs[11] = '{3'b011, 32'h7FFFFFFF, 32'd1,        1'b0, '{32'd1,         1'b0, 1'b0, 1'b0, 34}};

    reset = 1'b1;
    start = 1'b0;
    aluOp = 3'b000;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy",      {31'd0, busy},     32'd0);
    checkOutput("reset done",      {31'd0, done},     32'd0);
    checkOutput("reset result",    result,            32'd0);
    checkOutput("reset zero",      {31'd0, zero},     32'd0);
    checkOutput("reset carry_out", {31'd0, carryOut}, 32'd0);
    checkOutput("reset overflow",  {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed table");
    for (int i = 0; i < 12; i++) begin
      runAndCheck($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].hold, vecs[i].e);
    end

    $display("[TB] reset abort sequence");
    start = 1'b1;
    aluOp = 3'b001;
    a     = 32'hFFFFFFFF;
    b     = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("abort busy",      {31'd0, busy},     32'd0);
    checkOutput("abort done",      {31'd0, done},     32'd0);
    checkOutput("abort result",    result,            32'd0);
    checkOutput("abort zero",      {31'd0, zero},     32'd0);
    checkOutput("abort carry_out", {31'd0, carryOut}, 32'd0);
    checkOutput("abort overflow",  {31'd0, overflow}, 32'd0);
    @(posedge clk); #1;
    reset    = 1'b0;
    doneSeen = 0;
    busySeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) doneSeen++;
      if (busy) busySeen++;
    end
    checkOutput("abort no done", 32'(doneSeen), 32'd0);
    checkOutput("abort no busy", 32'(busySeen), 32'd0);
    e = '{32'd7, 1'b0, 1'b1, 1'b0, 33};
    runAndCheck("post-abort sub", 3'b101, 32'd10, 32'd3, 1'b0, e);

    $display("[TB] randomized operations");
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 4) == 0) ? ra : $urandom;
      if (i % 10 == 3) ra = 32'h80000000;
      if (i % 10 == 7) rb = 32'hFFFFFFFF;
      e = refModel(rop, ra, rb);
      runAndCheck($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, bit'($urandom_range(0, 1)), e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_serial_ctrl.md
# alu_serial_ctrl

Bit-serial ALU sequencer for the 32-bit MIPS datapath. It accepts a full-width operation through a start/done handshake and drives a single 1-bit ALU slice for WIDTH cycles, LSB first. A carry flop links the bits, and an extra fix-up cycle handles set-less-than. Use it in area-constrained builds in place of the 32-slice ripple ALU; the execute stage stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand/result width. Must be ≥2.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; forces IDLE and clears every register
- `start`  in  1  request; sampled only in IDLE
- `alu_op`  in  3  operation code, latched on accept
- `a`  in  WIDTH  operand A, latched on accept
- `b`  in  WIDTH  operand B, latched on accept
- `busy`  out  1  high in RUN and SLT
- `done`  out  1  one-cycle pulse in DONE
- `result`  out  WIDTH  result; held until the next accept
- `zero`  out  1  result==0, updated with result
- `carry_out`  out  1  final carry out of the MSB
- `overflow`  out  1  signed overflow for ADD/SUB, else 0

## Operation
- Op codes: 000 AND, 001 ADD, 010 OR, 011 SLT-on-sum, 100 AND-NOT (a&~b), 101 SUB, 110 OR-NOT (a|~b), 111 SLT.
- Bit 2 inverts b. It also seeds carry-in to 1, so SUB is two's-complement.
- States: IDLE, RUN, SLT, DONE.
- IDLE -> RUN when `start`=1 at a clock edge. On that edge:
  - Latch a, b and op into shift registers.
  - Set carry flop = alu_op[2].
  - Set bit counter = 0.
  - Clear the result shift register.
- RUN, each cycle, with bit i = count:
  - Inputs: ai = a_sh[0], bi = b_sh[0] ^ op[2].
  - Sum = ai^bi^c.
  - Next carry = (ai&bi) | (c&(ai^bi)).
  - Output bit: op[1:0] 00 -> ai&bi; 01 -> sum; 10 -> ai|bi; 11 -> 0.
  - Shift the output bit into the result MSB (shift right).
  - Shift a_sh and b_sh right.
  - Update the carry flop every cycle, for all ops.
  - At count = WIDTH-1:
    - Capture the carry into the MSB (c_msb_in).
    - Capture the sum bit (msb_sum).
    - Go to SLT if op[1:0]=11, else DONE.
- SLT, one cycle: result[0] <= msb_sum (sign of a-b for 111, sign of a+b for 011). All other result bits stay 0. Go to DONE.
- DONE, one cycle:
  - `done`=1.
  - Registered outputs become visible: zero, carry_out = final carry flop, overflow = (c_msb_in ^ final carry) when op[1:0]=01, else 0.
  - Go to IDLE.
- `start` outside IDLE is ignored; it is not queued.
- SLT ignores overflow, as the MIPS slt reference does.
- Counter is 5 bits for WIDTH=32 (general: clog2(WIDTH)). It is compared, never allowed to wrap.

## Timing
- Accept edge T (IDLE, start=1).
- RUN occupies cycles T+1..T+WIDTH.
- Non-SLT: DONE at T+WIDTH+1, so start-to-done latency is 33 cycles.
- SLT: SLT state at T+WIDTH+1, DONE at T+WIDTH+2, so latency is 34 cycles.
- Earliest next accept is the edge at the end of the IDLE cycle after DONE. Back-to-back throughput is 34/35 cycles.
- `busy` rises the cycle after accept and falls when DONE is entered.
- `result`, `zero`, `carry_out` and `overflow` are stable from DONE until the next accept edge, where result clears.
- Reset values: state IDLE; busy 0, done 0, result 0, zero 0, carry_out 0, overflow 0; counter and shift registers 0.
- Reset mid-operation aborts immediately, with no done pulse. The first start after deassertion begins a fresh operation.
- Operand changes after the accept edge have no effect.

## Test plan
- ADD a=7, b=5, start at T -> busy T+1..T+32, done only at T+33, result=12, carry_out=0, overflow=0, zero=0.
- SUB a=5, b=7 -> result=0xFFFFFFFE, carry_out=0, overflow=0. Then SUB a=0x80000000, b=1 -> result=0x7FFFFFFF, overflow=1.
- ADD a=0x7FFFFFFF, b=1 -> 0x80000000, overflow=1. Then ADD a=0xFFFFFFFF, b=1 -> 0, carry_out=1, zero=1.
- SLT a=0xFFFFFFFF, b=1 -> result=1, done at T+34. Then SLT a=3, b=3 -> result=0, zero=1.
- AND/OR/AND-NOT/OR-NOT with a=0xF0F0A5A5, b=0xFF00FF00 -> 0xF000A500, 0xFFF0FFA5, 0x00F000A5, 0xF0FFA5FF. Hold start high throughout busy -> exactly one done per operation, no re-accept until IDLE.
- Reset asserted asynchronously at T+10 of an ADD -> outputs 0 and busy 0 immediately, no done. Then SUB a=10, b=3 -> result=7 at T'+33.
